// File: rtl/fpaddsub_round_pipe_if.sv
// Operand/result bundle for the FP add/sub round-and-pack stage.
// Result is packed {sign, exponent, mantissa}; flag order is {Inv, Ovf, Udf, Inx}.
interface fpaddsub_round_pipe_if #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10
);
  localparam int DWIDTH = EXPONENT + MANTISSA + 1;

  logic                in_valid;
  logic                in_ready;
  logic [MANTISSA-1:0] NormM;
  logic [EXPONENT:0]   NormE;
  logic                FG;
  logic                R;
  logic                S;
  logic                ZeroSum;
  logic                NegE;
  logic                Sgn;
  logic                InNaN;
  logic                InInf;
  logic                out_valid;
  logic                out_ready;
  logic [DWIDTH-1:0]   Result;
  logic                OvfF;
  logic                UdfF;
  logic                InxF;
  logic                InvF;
  logic                flags_clr;
  logic [3:0]          StickyFlags;

  modport master (
    output in_valid, NormM, NormE, FG, R, S, ZeroSum, NegE, Sgn, InNaN, InInf,
    output out_ready, flags_clr,
    input  in_ready, out_valid, Result, OvfF, UdfF, InxF, InvF, StickyFlags
  );

  modport slave (
    input  in_valid, NormM, NormE, FG, R, S, ZeroSum, NegE, Sgn, InNaN, InInf,
    input  out_ready, flags_clr,
    output in_ready, out_valid, Result, OvfF, UdfF, InxF, InvF, StickyFlags
  );
endinterface

// File: rtl/fpaddsub_round_pipe.sv
// Two-stage round-to-nearest-even and pack stage with valid/ready flow control
// and sticky exception flags.
module fpaddsub_round_pipe #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10
) (
  input logic                clk,
  input logic                rst,
  fpaddsub_round_pipe_if.slave bus
);
  localparam int DWIDTH = EXPONENT + MANTISSA + 1;

  logic                s1Valid;
  logic                s2Valid;
  logic                s1Adv;
  logic                s2Adv;
  logic                accept;
  logic                inc;
  logic [MANTISSA:0]   mInc;
  logic [MANTISSA-1:0] s1Mant;
  logic                s1Cout;
  logic                s1Inexact;
  logic [EXPONENT:0]   s1NormE;
  logic                s1Zero;
  logic                s1NegE;
  logic                s1Sgn;
  logic                s1NaN;
  logic                s1Inf;
  logic [EXPONENT:0]   rExp;
  logic [DWIDTH-1:0]   nxtResult;
  logic [3:0]          nxtFlags;
  logic [DWIDTH-1:0]   result;
  logic [3:0]          flags;
  logic [3:0]          sticky;

  assign s2Adv  = ~s2Valid | bus.out_ready;
  assign s1Adv  = ~s1Valid | s2Adv;
  assign accept = bus.in_valid & s1Adv;

  assign inc  = bus.FG & (bus.R | bus.S | bus.NormM[0]);
  assign mInc = {1'b0, bus.NormM} + {{MANTISSA{1'b0}}, inc};
  assign rExp = s1NormE + {{EXPONENT{1'b0}}, s1Cout};

  // Special cases take priority over the rounded value, in this order.
  always_comb begin
    nxtResult = '0;
    nxtFlags  = '0;
    if (s1NaN) begin
      nxtResult = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};
      nxtFlags  = 4'b1000;
    end else if (s1Inf) begin
      nxtResult = {s1Sgn, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
    end else if (s1Zero) begin
      nxtResult = '0;
    end else if (s1NegE | s1NormE[EXPONENT] | (rExp == '0)) begin
      nxtResult = {s1Sgn, {(DWIDTH-1){1'b0}}};
      nxtFlags  = 4'b0011;
    end else if ((&rExp[EXPONENT-1:0]) | rExp[EXPONENT]) begin
      nxtResult = {s1Sgn, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      nxtFlags  = 4'b0101;
    end else begin
      nxtResult = {s1Sgn, rExp[EXPONENT-1:0], s1Mant};
      nxtFlags  = {3'b000, s1Inexact};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1Valid   <= 1'b0;
      s2Valid   <= 1'b0;
      s1Mant    <= '0;
      s1Cout    <= 1'b0;
      s1Inexact <= 1'b0;
      s1NormE   <= '0;
      s1Zero    <= 1'b0;
      s1NegE    <= 1'b0;
      s1Sgn     <= 1'b0;
      s1NaN     <= 1'b0;
      s1Inf     <= 1'b0;
      result    <= '0;
      flags     <= '0;
      sticky    <= '0;
    end else begin
      if (s1Adv) begin
        s1Valid <= bus.in_valid;
        if (accept) begin
          s1Mant    <= mInc[MANTISSA-1:0];
          s1Cout    <= mInc[MANTISSA];
          s1Inexact <= bus.FG | bus.R | bus.S;
          s1NormE   <= bus.NormE;
          s1Zero    <= bus.ZeroSum;
          s1NegE    <= bus.NegE;
          s1Sgn     <= bus.Sgn;
          s1NaN     <= bus.InNaN;
          s1Inf     <= bus.InInf;
        end
      end
      if (s2Adv) begin
        s2Valid <= s1Valid;
        if (s1Valid) begin
          result <= nxtResult;
          flags  <= nxtFlags;
        end
      end
      // A clear in the same cycle as a transfer keeps only the new flags.
      if (s2Valid & bus.out_ready) begin
        sticky <= bus.flags_clr ? flags : (sticky | flags);
      end else if (bus.flags_clr) begin
        sticky <= '0;
      end
    end
  end

  assign bus.in_ready    = ~s1Valid | ~s2Valid | bus.out_ready;
  assign bus.out_valid   = s2Valid;
  assign bus.Result      = result;
  assign bus.InvF        = flags[3];
  assign bus.OvfF        = flags[2];
  assign bus.UdfF        = flags[1];
  assign bus.InxF        = flags[0];
  assign bus.StickyFlags = sticky;
endmodule
